// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between requester A (instruction fetch) and
// requester B (data load/store). Each grant holds mem_en for MEM_LAT cycles,
// then pulses the winner's done and spends one RESP cycle before returning
// to IDLE. Ties resolve round-robin, or always to B when FIXED_PRI is set.
// Every output is a flop; the combinational block below only computes the
// next value of each one.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT   = 3,  // 1..15
    parameter int unsigned FIXED_PRI = 0   // 0: round-robin, 1: B wins ties
) (
    input  logic Clk,
    input  logic Rst,
    input  logic reqA,
    input  logic reqB,
    input  logic weB,
    output logic sel,
    output logic mem_en,
    output logic mem_we,
    output logic gntA,
    output logic gntB,
    output logic doneA,
    output logic doneB,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1  = 4'(MEM_LAT - 1);
    localparam logic       B_FIXED = (FIXED_PRI != 0);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       last, last_n;       // 1 = B was granted most recently
    logic       win_b;
    logic       sel_n, mem_en_n, mem_we_n;
    logic       gnta_n, gntb_n, donea_n, doneb_n, busy_n;

    // Winner if arbitration happens this cycle: a lone requester always wins;
    // on a tie B wins when it has fixed priority or when A went last.
    always_comb begin
        win_b = reqB && (!reqA || B_FIXED || !last);
    end

    // Next state and next value of every registered output.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last;
        sel_n    = sel;
        mem_en_n = mem_en;
        mem_we_n = mem_we;
        gnta_n   = gntA;
        gntb_n   = gntB;
        donea_n  = 1'b0;
        doneb_n  = 1'b0;
        busy_n   = busy;

        case (state)
            IDLE: begin
                mem_en_n = 1'b0;
                mem_we_n = 1'b0;
                gnta_n   = 1'b0;
                gntb_n   = 1'b0;
                busy_n   = 1'b0;
                if (reqA || reqB) begin
                    sel_n    = win_b;
                    gnta_n   = !win_b;
                    gntb_n   = win_b;
                    mem_en_n = 1'b1;
                    mem_we_n = win_b && weB;
                    busy_n   = 1'b1;
                    cnt_n    = LAT_M1;
                    state_n  = ACCESS;
                end
            end

            ACCESS: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    mem_en_n = 1'b0;
                    mem_we_n = 1'b0;
                    gnta_n   = 1'b0;
                    gntb_n   = 1'b0;
                    donea_n  = gntA;
                    doneb_n  = gntB;
                    last_n   = gntB;
                    state_n  = RESP;
                end
            end

            RESP: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counter, round-robin pointer and output registers; reset wins.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            sel    <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            gntA   <= 1'b0;
            gntB   <= 1'b0;
            doneA  <= 1'b0;
            doneB  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            last   <= last_n;
            sel    <= sel_n;
            mem_en <= mem_en_n;
            mem_we <= mem_we_n;
            gntA   <= gnta_n;
            gntB   <= gntb_n;
            doneA  <= donea_n;
            doneB  <= doneb_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Three arbiters side by side: (MEM_LAT=3, round-robin), (MEM_LAT=3,
// B fixed priority) and (MEM_LAT=1, round-robin). A timeline model tracks
// each access as a position counted from its grant edge and predicts every
// output every cycle; directed steps are followed by a random phase.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rs [3];
    logic ra [3];
    logic rb [3];
    logic wb [3];
    logic o_sel [3];
    logic o_en [3];
    logic o_we [3];
    logic o_ga [3];
    logic o_gb [3];
    logic o_da [3];
    logic o_db [3];
    logic o_busy [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(
            .MEM_LAT   (g == 2 ? 1 : 3),
            .FIXED_PRI (g == 1 ? 1 : 0)
        ) dut (
            .Clk    (clk),
            .Rst    (rs[g]),
            .reqA   (ra[g]),
            .reqB   (rb[g]),
            .weB    (wb[g]),
            .sel    (o_sel[g]),
            .mem_en (o_en[g]),
            .mem_we (o_we[g]),
            .gntA   (o_ga[g]),
            .gntB   (o_gb[g]),
            .doneA  (o_da[g]),
            .doneB  (o_db[g]),
            .busy   (o_busy[g])
        );
    end

    // Model: pos = cycles since grant edge (-1 idle); 0..lat-1 memory
    // enabled, lat = done/response cycle, then idle again.
    int lat [3] = '{3, 3, 1};
    bit fp  [3] = '{1'b0, 1'b1, 1'b0};
    int pos [3] = '{-1, -1, -1};
    bit own [3];
    bit lst [3];
    bit msel [3];
    bit mwe [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int en_cnt [3];
    int we_cnt [3];
    int da_cnt [3];
    int db_cnt [3];
    logic pga [2];
    logic pgb [2];
    int gseq0 [$];
    int gtim0 [$];
    int gseq1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs now driven.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rs[k]) begin
                pos[k]  = -1;
                lst[k]  = 1'b1;
                msel[k] = 1'b0;
                mwe[k]  = 1'b0;
                own[k]  = 1'b0;
            end else if (pos[k] < 0) begin
                if (ra[k] || rb[k]) begin
                    bit w;
                    if (ra[k] && rb[k]) w = fp[k] ? 1'b1 : !lst[k];
                    else                w = rb[k];
                    own[k]  = w;
                    msel[k] = w;
                    mwe[k]  = wb[k];
                    pos[k]  = 0;
                end
            end else if (pos[k] < lat[k]) begin
                pos[k]++;
                if (pos[k] == lat[k]) lst[k] = own[k];
            end else begin
                pos[k] = -1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic en, bz, dn;
            string p;
            p  = $sformatf("d%0d.", k);
            en = (pos[k] >= 0) && (pos[k] < lat[k]);
            bz = (pos[k] >= 0) && (pos[k] <= lat[k]);
            dn = (pos[k] == lat[k]);
            chk({p, "sel"},    32'(o_sel[k]),  32'(msel[k]));
            chk({p, "mem_en"}, 32'(o_en[k]),   32'(en));
            chk({p, "mem_we"}, 32'(o_we[k]),   32'(en && own[k] && mwe[k]));
            chk({p, "gntA"},   32'(o_ga[k]),   32'(en && !own[k]));
            chk({p, "gntB"},   32'(o_gb[k]),   32'(en && own[k]));
            chk({p, "doneA"},  32'(o_da[k]),   32'(dn && !own[k]));
            chk({p, "doneB"},  32'(o_db[k]),   32'(dn && own[k]));
            chk({p, "busy"},   32'(o_busy[k]), 32'(bz));
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
        for (int k = 0; k < 3; k++) begin
            if (o_en[k] === 1'b1) en_cnt[k]++;
            if (o_we[k] === 1'b1) we_cnt[k]++;
            if (o_da[k] === 1'b1) da_cnt[k]++;
            if (o_db[k] === 1'b1) db_cnt[k]++;
        end
        if (o_ga[0] === 1'b1 && pga[0] !== 1'b1) begin gseq0.push_back(0); gtim0.push_back(cyc); end
        if (o_gb[0] === 1'b1 && pgb[0] !== 1'b1) begin gseq0.push_back(1); gtim0.push_back(cyc); end
        if (o_ga[1] === 1'b1 && pga[1] !== 1'b1) gseq1.push_back(0);
        if (o_gb[1] === 1'b1 && pgb[1] !== 1'b1) gseq1.push_back(1);
        for (int k = 0; k < 2; k++) begin
            pga[k] = o_ga[k];
            pgb[k] = o_gb[k];
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 3; k++) begin
            en_cnt[k] = 0;
            we_cnt[k] = 0;
            da_cnt[k] = 0;
            db_cnt[k] = 0;
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic b, input logic w);
        for (int k = 0; k < 3; k++) begin
            rs[k] = r;
            ra[k] = a;
            rb[k] = b;
            wb[k] = w;
        end
    endtask

    initial begin
        // Reset for two cycles, then ten quiet idle cycles.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();

        // Single A access, request dropped right after the grant edge.
        clr();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        chk("A.en_cycles.d0", en_cnt[0], 3);
        chk("A.en_cycles.d1", en_cnt[1], 3);
        chk("A.en_cycles.d2", en_cnt[2], 1);
        chk("A.doneA.d0", da_cnt[0], 1);
        chk("A.doneA.d2", da_cnt[2], 1);
        chk("A.mem_we.d0", we_cnt[0], 0);

        // B write; weB flips to 0 after the grant and must be ignored.
        clr();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        chk("B.we_cycles.d0", we_cnt[0], 3);
        chk("B.we_cycles.d1", we_cnt[1], 3);
        chk("B.we_cycles.d2", we_cnt[2], 1);
        chk("B.doneB.d0", db_cnt[0], 1);
        chk("B.doneB.d2", db_cnt[2], 1);

        // Both requests held: round-robin alternates, fixed priority starves A
        // until B drops.
        gseq0.delete();
        gtim0.delete();
        gseq1.delete();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (20) tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        chk("rr.num_grants", 32'(gseq0.size() >= 4), 1);
        if (gseq0.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr.order[%0d]", i), gseq0[i], i % 2);
            for (int i = 1; i < 4; i++) chk($sformatf("rr.spacing[%0d]", i), gtim0[i] - gtim0[i-1], 5);
        end
        chk("fp.num_grants", 32'(gseq1.size() >= 5), 1);
        if (gseq1.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk($sformatf("fp.order[%0d]", i), gseq1[i], 1);
            chk("fp.after_drop", gseq1[4], 0);
        end

        // Reset in the second access cycle of an A access: no done, and the
        // round-robin pointer goes back to favouring A.
        clr();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst.doneA.d0", da_cnt[0], 0);
        chk("rst.doneA.d1", da_cnt[1], 0);
        chk("rst.busy.d0", 32'(o_busy[0]), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("rst.first_gntA.d0", 32'(o_ga[0]), 1);
        chk("rst.first_gntA.d2", 32'(o_ga[2]), 1);
        chk("rst.first_gntB.d1", 32'(o_gb[1]), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();

        // Random traffic with occasional resets, independent per instance.
        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                rs[k] = ($urandom_range(0, 99) == 0);
                ra[k] = 1'($urandom_range(0, 1));
                rb[k] = 1'($urandom_range(0, 1));
                wb[k] = 1'($urandom_range(0, 1));
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
